// File: rtl/char_ram_pkg.sv
// Shared defaults and the buffered CPU write entry
// for the character RAM arbiter.
package char_ram_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int STALL_MAX_DEF  = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/char_ram_arbiter_if.sv
// CPU write, VGA fetch and RAM port bundle
// for the character RAM arbiter.
interface char_ram_arbiter_if
  import char_ram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
);

  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CW-1:0]     fifo_count;
  logic              drop_err;

  modport master (
    output cpu_we, cpu_addr, cpu_wdata,
    output vga_req, vga_addr, ram_rdata,
    input  cpu_ready, vga_gnt, vga_rvalid,
    input  vga_rdata, ram_en, ram_we,
    input  ram_addr, ram_wdata,
    input  fifo_count, drop_err
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata,
    input  vga_req, vga_addr, ram_rdata,
    output cpu_ready, vga_gnt, vga_rvalid,
    output vga_rdata, ram_en, ram_we,
    output ram_addr, ram_wdata,
    output fifo_count, drop_err
  );

endinterface

// File: rtl/char_wr_fifo.sv
// Circular write buffer holding CPU writes
// until the arbiter drains them to the RAM.
module char_wr_fifo
  import char_ram_pkg::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH_DEF,
  parameter type entry_t = wr_entry_t,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock_50,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wr_data,
  output entry_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock_50) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/char_ram_arbiter.sv
// Single-port character RAM shared by buffered CPU
// writes and VGA fetches, with write starvation guard.
module char_ram_arbiter
  import char_ram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STALL_MAX  = STALL_MAX_DEF
) (
  input logic               clock_50,
  input logic               reset,
  char_ram_arbiter_if.slave bus
);

  localparam int SW = $clog2(STALL_MAX + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            push_d;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              force_wr;
  logic              wr_gnt;
  logic              rd_gnt;
  logic [CW-1:0]     count;
  logic [SW-1:0]     stall_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  char_wr_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock_50 (clock_50),
    .reset    (reset),
    .push     (push),
    .pop      (wr_gnt),
    .wr_data  (push_d),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign push   = bus.cpu_we && !full;
  assign push_d = '{addr: bus.cpu_addr, data: bus.cpu_wdata};

  // A starved or full buffer pre-empts VGA for one cycle
  assign force_wr = !empty &&
    (stall_cnt == SW'(STALL_MAX) || full);
  assign wr_gnt = !reset && !empty &&
    (force_wr || !bus.vga_req);
  assign rd_gnt = !reset && bus.vga_req && !force_wr;

  assign bus.cpu_ready  = !full;
  assign bus.vga_gnt    = rd_gnt;
  assign bus.vga_rdata  = bus.ram_rdata;
  assign bus.fifo_count = count;

  always_comb begin
    bus.ram_en    = wr_gnt || rd_gnt;
    bus.ram_we    = wr_gnt;
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    unique case (1'b1)
      wr_gnt: begin
        bus.ram_addr  = head.addr;
        bus.ram_wdata = head.data;
      end
      rd_gnt: bus.ram_addr = bus.vga_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      stall_cnt      <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.drop_err   <= 1'b0;
      bus.vga_rvalid <= 1'b0;
    end else begin
      bus.vga_rvalid <= rd_gnt;
      if (bus.cpu_we && full) bus.drop_err <= 1'b1;
      if (bus.ram_en) begin
        addr_q  <= bus.ram_addr;
        wdata_q <= bus.ram_wdata;
      end
      if (empty || wr_gnt)
        stall_cnt <= '0;
      else if (stall_cnt != SW'(STALL_MAX))
        stall_cnt <= stall_cnt + SW'(1);
    end
  end

endmodule

// File: doc/char_ram_arbiter.md
CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, character address width; DATA_W, default 8, character width; FIFO_DEPTH, default 4, CPU write buffer entries; STALL_MAX, default 8, maximum cycles a buffered write waits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports are listed below.
REQ-003 clock_50  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_we  in  1  CPU write request; offered for one cycle per write.
REQ-006 cpu_addr  in  ADDR_W  CPU character address.
REQ-007 cpu_wdata  in  DATA_W  CPU character data.
REQ-008 cpu_ready  out  1  high when the write buffer can accept a write this cycle.
REQ-009 vga_req  in  1  VGA fetch request; held until granted.
REQ-010 vga_addr  in  ADDR_W  VGA fetch address.
REQ-011 vga_gnt  out  1  VGA fetch granted this cycle.
REQ-012 vga_rvalid  out  1  vga_rdata valid; asserted one cycle after vga_gnt.
REQ-013 vga_rdata  out  DATA_W  fetched character; equals ram_rdata.
REQ-014 ram_en, ram_we  out  1 each  single-port RAM enable and write strobe.
REQ-015 ram_addr  out  ADDR_W  RAM address.
REQ-016 ram_wdata  out  DATA_W  RAM write data.
REQ-017 ram_rdata  in  DATA_W  RAM read data, one-cycle latency.
REQ-018 fifo_count  out  clog2(FIFO_DEPTH)+1  buffered write count.
REQ-019 drop_err  out  1  sticky flag: a write was offered while cpu_ready was low.

Function
REQ-020 A write SHALL be accepted only when cpu_we=1 and cpu_ready=1; the accepted {addr,data} is pushed into the FIFO that cycle.
REQ-021 cpu_ready SHALL equal (fifo_count < FIFO_DEPTH).
REQ-022 When cpu_we=1 and cpu_ready=0, the write SHALL be discarded and drop_err SHALL be set until reset.
REQ-023 A push and a pop in the same cycle SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Arbitration SHALL be combinational per cycle, with at most one RAM access per cycle.
REQ-025 Normal priority: VGA wins when vga_req=1; otherwise, if the FIFO is non-empty, the head write is performed (ram_en=1, ram_we=1) and popped.
REQ-026 stall_cnt SHALL increment each cycle the FIFO is non-empty and no write is granted, saturate at STALL_MAX, and clear on any write grant or when the FIFO is empty.
REQ-027 When stall_cnt=STALL_MAX or fifo_count=FIFO_DEPTH, the write SHALL be granted even if vga_req=1; vga_gnt SHALL then be 0 and VGA retries.
REQ-028 On a VGA grant: ram_en=1, ram_we=0, ram_addr=vga_addr; vga_rvalid=1 on the next cycle, with vga_rdata=ram_rdata.
REQ-029 Reads SHALL return RAM contents only; buffered, undrained writes are not forwarded to reads.
REQ-030 With no grant, ram_en=0, ram_we=0, and ram_addr/ram_wdata hold their previous values.

Reset
REQ-031 While reset=1: FIFO empty, fifo_count=0, stall_cnt=0, drop_err=0, vga_rvalid=0, ram_en=0, ram_we=0, cpu_ready=1, vga_gnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered writes and any pending vga_rvalid immediately.

Structure
REQ-033 Package char_ram_pkg SHALL hold the ADDR_W/DATA_W defaults, the FIFO_DEPTH/STALL_MAX defaults and the write-entry struct {addr,data}.
REQ-034 The FIFO SHALL be a sub-module char_wr_fifo (push/pop/full/empty/count); arbitration and stall logic SHALL reside in char_ram_arbiter.

Verification
REQ-035 Write 0x41 to addr 5 with vga_req=0 -> ram_we=1, addr 5, data 0x41 one cycle later; fifo_count returns to 0.
REQ-036 vga_req held with addr 3 while the FIFO is empty -> vga_gnt same cycle; vga_rvalid=1 next cycle with RAM[3].
REQ-037 vga_req held continuously; one write pushed -> write is granted after exactly 8 stalled cycles, vga_gnt=0 in that cycle.
REQ-038 5 back-to-back writes while vga_req=1 -> first 4 accepted, 5th dropped with drop_err=1; full FIFO forces a drain.
REQ-039 Push and drain in the same cycle with fifo_count=2 -> fifo_count stays 2.
REQ-040 Reset pulse with fifo_count=3 and vga_rvalid pending -> all outputs equal REQ-031 values; no RAM write follows.
